battle_front: RTL and testbench
===============================

Name: battle_front

Overview:
- Battlefront calculator for one enemy lane and one player lane.
- Divides the system clock into a game tick.
- Sequences a move phase, a settle phase and a damage phase on every tick.
- Provides each side with the opponent's frontmost position, the move/damage strobes, and the damage it must absorb.
- Sits directly upstream of the enemy unit: it drives that unit's moveSCEN, damageSCEN, unitFront and damageIn, and consumes its position, damageOut and enemyType.

Parameters:
- TICK_DIV, 50000: clk cycles per game tick; minimum legal value 8.
- FIELD_MAX, 9'd319: rightmost battlefield coordinate; the player spawn side.
- CRIT_PERIOD, 4: every CRIT_PERIOD-th damage phase is critical (only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enemyPos  in  9  enemy unit position
- enemyType  in  2  enemy type; 0 = not alive
- enemyDamageOut  in  8  enemy attack output
- playerPos  in  9  player unit position
- playerType  in  2  player type; 0 = not alive
- playerDamageOut  in  8  player attack output
- moveSCEN  out  1  one-cycle move strobe, shared by both sides
- damageSCEN  out  1  one-cycle damage strobe, shared by both sides
- enemyUnitFront  out  9  position the enemy compares against
- playerUnitFront  out  9  position the player compares against
- enemyDamageIn  out  8  damage applied to the enemy
- playerDamageIn  out  8  damage applied to the player
- contact  out  1  both sides alive and touching

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; all registers clear immediately on reset assertion.
- Reset values of outputs:
  - moveSCEN = 0, damageSCEN = 0, contact = 0
  - enemyDamageIn = 0, playerDamageIn = 0
  - enemyUnitFront = FIELD_MAX, playerUnitFront = 0
- Reset state: tick counter = 0, FSM = QIdle, crit counter = 0, latched damages = 0.
- Tick counter: increments every clk and wraps from TICK_DIV-1 to 0. tick = (count == TICK_DIV-1). It runs in every FSM state.
- FSM is one-hot with four states:
  - QIdle: on tick, go to QMove. A tick seen in any other state is ignored; this cannot occur while TICK_DIV >= 8.
  - QMove: moveSCEN = 1 for exactly this one cycle. Next state is QSettle.
  - QSettle: one cycle in which the units register damageOut. Next state is QDamage.
  - QDamage: damageSCEN = 1 for exactly this one cycle. Next state is QIdle.
- Latency: moveSCEN is high in the cycle after tick; damageSCEN is high exactly 2 cycles after moveSCEN.
- Strobes: all strobes and damage outputs are registered outputs.
- Fronts, registered every cycle:
  - enemyUnitFront = playerPos if playerType != 0, else FIELD_MAX.
  - playerUnitFront = enemyPos if enemyType != 0, else 0.
- Contact, registered: contact = (enemyType != 0) && (playerType != 0) && (enemyPos >= playerPos).
- Damage latch: at the end of QSettle, latch enemyDamageOut and playerDamageOut.
- Damage outputs:
  - enemyDamageIn = latched playerDamageOut and playerDamageIn = latched enemyDamageOut, only in the QDamage cycle and only if contact = 1.
  - Otherwise both are 0 in every cycle. This is mandatory: the unit kill check compares against damageIn continuously.
- Simultaneous death: both units may receive lethal damage in the same QDamage cycle. No priority is applied.
- Mid-sequence death: if a side's type drops to 0 during QMove or QSettle, contact falls, QDamage outputs 0 damage, and damageSCEN still pulses.
- Reset mid-sequence: the sequence is abandoned, and no strobe appears after reset is released until the next tick.
- Arithmetic: 9-bit unsigned compare, no wrap.

Optional Feature:
- Macro: BATTLE_CRIT_EN.
- Defined:
  - A 3-bit crit counter increments on each QDamage cycle in which contact = 1, wrapping at CRIT_PERIOD-1.
  - When the counter equals CRIT_PERIOD-1, enemyDamageIn is doubled, saturating at 8'hFF.
  - Only the player's hit on the enemy is doubled.
- Undefined: no crit counter exists, and damage passes through unmodified.

Decomposition:
- Package battle_pkg holds:
  - the state encodings QIdle/QMove/QSettle/QDamage
  - POS_W = 9, DMG_W = 8
  - the unit type codes (00 = none, 01..11 = tiers)
  - FIELD_MAX
- One sub-module, tick_gen, holds the TICK_DIV counter with a one-cycle tick output.

Test Plan:
1. TICK_DIV = 8, both sides alive, enemyPos = 10, playerPos = 100:
   - moveSCEN pulses once every 8 cycles.
   - damageSCEN follows 2 cycles later.
   - Both damageIn outputs stay 0 and contact = 0.
2. enemyPos = 50, playerPos = 50, enemyDamageOut = 0x20, playerDamageOut = 0x40:
   - In the QDamage cycle, enemyDamageIn = 0x40 and playerDamageIn = 0x20.
   - In all other cycles, both are 0.
3. playerType = 0, enemyPos = 30: enemyUnitFront = 319 and playerUnitFront = 30. Then enemyType = 0: playerUnitFront = 0.
4. Reset asserted during QSettle:
   - All outputs clear in the same cycle.
   - No damageSCEN appears.
   - The first moveSCEN after release occurs 8 cycles later.
5. In contact, enemyType drops to 0 during QMove: damageSCEN pulses with both damageIn = 0.
6. With BATTLE_CRIT_EN and playerDamageOut = 0x90, in contact:
   - Damage phases 1–3 give enemyDamageIn = 0x90.
   - Phase 4 gives 0xFF (saturated).
   - Phase 5 gives 0x90.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared definitions for the battlefront calculator: FSM state encodings,
// datapath widths, unit type codes and the battlefield extent.
package battle_pkg;

  localparam int POS_W = 9;
  localparam int DMG_W = 8;

  // Rightmost battlefield coordinate; the player spawns on this side.
  localparam logic [POS_W-1:0] FIELD_MAX = 9'd319;

  // One-hot phase encoding for the per-tick sequence.
  typedef enum logic [3:0] {
    QIdle   = 4'b0001,
    QMove   = 4'b0010,
    QSettle = 4'b0100,
    QDamage = 4'b1000
  } state_t;

  // Unit type codes; NONE means the lane is empty.
  typedef enum logic [1:0] {
    UNIT_NONE = 2'b00,
    UNIT_T1   = 2'b01,
    UNIT_T2   = 2'b10,
    UNIT_T3   = 2'b11
  } unit_t;

  function automatic logic unit_alive(input logic [1:0] t);
    return t != UNIT_NONE;
  endfunction

endpackage

// File: rtl/battle_front_tick_gen.sv
// Game tick divider: counts TICK_DIV clk cycles and flags the last one.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Free-running modulo-TICK_DIV counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/battle_front.sv
// Battlefront calculator for one enemy lane and one player lane.
// Each game tick runs move -> settle -> damage; fronts and contact are
// refreshed every cycle. Optional build macro: BATTLE_CRIT_EN adds a
// periodic critical hit on the player's attack against the enemy.
module battle_front import battle_pkg::*; #(
  parameter int               TICK_DIV  = 50000,
  parameter logic [POS_W-1:0] FIELD_MAX = battle_pkg::FIELD_MAX
`ifdef BATTLE_CRIT_EN
  , parameter int             CRIT_PERIOD = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] enemyPos,
  input  logic [1:0]       enemyType,
  input  logic [DMG_W-1:0] enemyDamageOut,
  input  logic [POS_W-1:0] playerPos,
  input  logic [1:0]       playerType,
  input  logic [DMG_W-1:0] playerDamageOut,
  output logic             moveSCEN,
  output logic             damageSCEN,
  output logic [POS_W-1:0] enemyUnitFront,
  output logic [POS_W-1:0] playerUnitFront,
  output logic [DMG_W-1:0] enemyDamageIn,
  output logic [DMG_W-1:0] playerDamageIn,
  output logic             contact
);

  state_t           r_state;
  logic             w_tick;
  logic             w_contact;
  logic [DMG_W-1:0] w_hitEnemy;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  assign w_contact = unit_alive(enemyType) && unit_alive(playerType) &&
                     (enemyPos >= playerPos);

`ifdef BATTLE_CRIT_EN
  localparam logic [2:0] CRIT_LAST = 3'(CRIT_PERIOD - 1);

  logic [2:0] r_crit;

  function automatic logic [DMG_W-1:0] sat_double(input logic [DMG_W-1:0] d);
    logic [DMG_W:0] s;
    s = {d, 1'b0};
    return s[DMG_W] ? {DMG_W{1'b1}} : s[DMG_W-1:0];
  endfunction

  // Count landed hits; the counter value seen while settling decides the crit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crit <= '0;
    end else if ((r_state == QDamage) && contact) begin
      r_crit <= (r_crit == CRIT_LAST) ? 3'd0 : r_crit + 3'd1;
    end
  end

  assign w_hitEnemy = (r_crit == CRIT_LAST) ? sat_double(playerDamageOut)
                                            : playerDamageOut;
`else
  assign w_hitEnemy = playerDamageOut;
`endif

  // Phase sequencer; the damage output registers double as the damage latch,
  // loaded from the units' damageOut on the edge that ends QSettle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= QIdle;
      moveSCEN       <= 1'b0;
      damageSCEN     <= 1'b0;
      enemyDamageIn  <= '0;
      playerDamageIn <= '0;
    end else begin
      moveSCEN       <= 1'b0;
      damageSCEN     <= 1'b0;
      enemyDamageIn  <= '0;
      playerDamageIn <= '0;
      case (r_state)
        QIdle: begin
          if (w_tick) begin
            r_state  <= QMove;
            moveSCEN <= 1'b1;
          end
        end
        QMove:   r_state <= QSettle;
        QSettle: begin
          r_state    <= QDamage;
          damageSCEN <= 1'b1;
          if (w_contact) begin
            enemyDamageIn  <= w_hitEnemy;
            playerDamageIn <= enemyDamageOut;
          end
        end
        QDamage: r_state <= QIdle;
        default: r_state <= QIdle;
      endcase
    end
  end

  // Opponent fronts and contact flag, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enemyUnitFront  <= FIELD_MAX;
      playerUnitFront <= '0;
      contact         <= 1'b0;
    end else begin
      enemyUnitFront  <= unit_alive(playerType) ? playerPos : FIELD_MAX;
      playerUnitFront <= unit_alive(enemyType) ? enemyPos : '0;
      contact         <= w_contact;
    end
  end

endmodule

// File: tb/tb_battle_front.sv
// Directed bench for battle_front with a damage-phase scoreboard.
module tb_battle_front;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] enemyPos, playerPos;
  logic [1:0] enemyType, playerType;
  logic [7:0] enemyDamageOut, playerDamageOut;
  logic       moveSCEN, damageSCEN, contact;
  logic [8:0] enemyUnitFront, playerUnitFront;
  logic [7:0] enemyDamageIn, playerDamageIn;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int last_ref = 0;
  logic [15:0] sb[$];
  logic mv_d1 = 1'b0;
  logic mv_d2 = 1'b0;

  battle_front #(.TICK_DIV(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .enemyPos        (enemyPos),
    .enemyType       (enemyType),
    .enemyDamageOut  (enemyDamageOut),
    .playerPos       (playerPos),
    .playerType      (playerType),
    .playerDamageOut (playerDamageOut),
    .moveSCEN        (moveSCEN),
    .damageSCEN      (damageSCEN),
    .enemyUnitFront  (enemyUnitFront),
    .playerUnitFront (playerUnitFront),
    .enemyDamageIn   (enemyDamageIn),
    .playerDamageIn  (playerDamageIn),
    .contact         (contact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_strobe(input bit dmg, input string name);
    bit seen = 1'b0;
    nvec++;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dmg ? damageSCEN : moveSCEN) seen = 1'b1;
    end
    if (!seen) begin
      nfail++;
      $display("FAIL %s: got 0 strobes in 40 cycles required 1", name);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_moveSCEN"}, moveSCEN, 0);
    chk({tag, "_damageSCEN"}, damageSCEN, 0);
    chk({tag, "_contact"}, contact, 0);
    chk({tag, "_enemyDamageIn"}, enemyDamageIn, 0);
    chk({tag, "_playerDamageIn"}, playerDamageIn, 0);
    chk({tag, "_enemyUnitFront"}, enemyUnitFront, 319);
    chk({tag, "_playerUnitFront"}, playerUnitFront, 0);
  endtask

  // Monitor: strobe timing and damage values against the scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (moveSCEN) begin
          chk("move_period", cyc - last_ref, 8);
          last_ref = cyc;
        end
        if (damageSCEN) begin
          chk("damage_after_move", int'(mv_d2), 1);
          if (sb.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_damage: got damageSCEN=1 required 0");
          end else begin
            e = sb.pop_front();
            chk("enemyDamageIn", enemyDamageIn, e[15:8]);
            chk("playerDamageIn", playerDamageIn, e[7:0]);
          end
        end else begin
          chk("idle_damage_zero", {enemyDamageIn, playerDamageIn}, 0);
        end
      end
      mv_d2 = mv_d1;
      mv_d1 = moveSCEN;
    end
  end

  // Stimulus
  initial begin
    enemyType = 2'd1; playerType = 2'd1;
    enemyPos = 9'd10; playerPos = 9'd100;
    enemyDamageOut = 8'h20; playerDamageOut = 8'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");

    // Separated units: strobes run, no damage, no contact.
    @(posedge clk); #1;
    reset = 1'b0; last_ref = cyc;
    sb.push_back(16'h0000); sb.push_back(16'h0000);
    wait_strobe(1'b1, "t1_damage1");
    chk("t1_contact", contact, 0);
    chk("t1_enemyUnitFront", enemyUnitFront, 100);
    chk("t1_playerUnitFront", playerUnitFront, 10);
    wait_strobe(1'b1, "t1_damage2");

    // Touching units exchange damage.
    @(posedge clk); #1;
    enemyPos = 9'd50; playerPos = 9'd50;
    sb.push_back(16'h4020);
    wait_strobe(1'b1, "t2_damage");
    chk("t2_contact", contact, 1);

    // Dead lanes report default fronts.
    @(posedge clk); #1;
    playerType = 2'd0; enemyPos = 9'd30;
    sb.push_back(16'h0000);
    @(posedge clk); @(negedge clk);
    chk("t3_enemyUnitFront", enemyUnitFront, 319);
    chk("t3_playerUnitFront", playerUnitFront, 30);
    chk("t3_contact", contact, 0);
    @(posedge clk); #1;
    enemyType = 2'd0;
    @(posedge clk); @(negedge clk);
    chk("t3_playerUnitFront_dead", playerUnitFront, 0);
    chk("t3_enemyUnitFront_dead", enemyUnitFront, 319);
    wait_strobe(1'b1, "t3_damage");

    // Enemy dies during QMove: damage phase still strobes, zero damage.
    @(posedge clk); #1;
    enemyType = 2'd1; playerType = 2'd1; enemyPos = 9'd50; playerPos = 9'd50;
    sb.push_back(16'h4020);
    wait_strobe(1'b1, "t5_pre_damage");
    @(posedge clk); #1;
    sb.push_back(16'h0000);
    wait_strobe(1'b0, "t5_move");
    enemyType = 2'd0;
    wait_strobe(1'b1, "t5_damage");

    // Reset during QSettle abandons the sequence.
    @(posedge clk); #1;
    enemyType = 2'd1;
    wait_strobe(1'b0, "t4_move");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("t4_rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; last_ref = cyc;
    wait_strobe(1'b0, "t4_move_after_reset");
    @(posedge clk); #1;
    sb.push_back(16'h4020);
    wait_strobe(1'b1, "t4_damage");

    // Five consecutive landed hits from a fresh reset.
    @(posedge clk); #1;
    reset = 1'b1; playerDamageOut = 8'h90;
    @(posedge clk); #1;
    reset = 1'b0; last_ref = cyc;
    sb.push_back(16'h9020); sb.push_back(16'h9020); sb.push_back(16'h9020);
`ifdef BATTLE_CRIT_EN
    sb.push_back(16'hFF20);
`else
    sb.push_back(16'h9020);
`endif
    sb.push_back(16'h9020);
    for (int k = 0; k < 5; k++) wait_strobe(1'b1, "t6_damage");
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
